// File: rtl/imem_stall_responder.sv
// Word-organised instruction/data memory responder for the fetch slot.
// Accepts one request, stalls a fixed or pseudo-random number of cycles, then pulses ready.
module imem_stall_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter bit          RAND_STALL  = 1'b0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);
  localparam logic [3:0]  LAT_FIX = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_out_q, data_out_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          lfsr_fb;
  logic          req_bad;
  logic [AW-1:0] widx;
  logic [31:0]   rdata;
  logic          mem_we;

  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5]
                 ^ lfsr_q[4] ^ lfsr_q[3];
  assign widx    = addr_q[AW+1:2];
  assign rdata   = mem[widx];
  assign req_bad = (addr_q[1:0] != 2'b00)
                 || (addr_q[31:2] >= DEPTH_W);

  // Next-state, latch and completion logic for the request FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lfsr_d     = lfsr_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    ready_d    = ready_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b0;
        err_d   = 1'b0;
        if (enable) begin
          addr_d  = addr;
          wr_d    = wr;
          wdata_d = data_in;
          if (RAND_STALL) begin
            cnt_d = {2'b00, lfsr_q[1:0]} + 4'd1;
          end else begin
            cnt_d = LAT_FIX;
          end
          // LFSR steps only on acceptance so the stall sequence is reproducible.
          lfsr_d  = {lfsr_q[6:0], lfsr_fb};
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          ready_d = 1'b1;
          err_d   = req_bad;
          if (req_bad) begin
            data_out_d = NOP_WORD;
          end else if (!wr_q) begin
            data_out_d = rdata;
          end else begin
            mem_we = 1'b1;
          end
        end
      end
      S_DONE: begin
        ready_d = 1'b0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      lfsr_q     <= LFSR_SEED;
      addr_q     <= 32'd0;
      wr_q       <= 1'b0;
      wdata_q    <= 32'd0;
      data_out_q <= NOP_WORD;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  // RAM write at the completion edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[widx] <= wdata_q;
    end
  end

  assign data_out = data_out_q;
  assign ready    = ready_q;
  assign err      = err_q;
  assign busy     = (state_q == S_BUSY);

endmodule

// File: tb/tb_imem_stall_responder.sv
// Randomised bench for imem_stall_responder against a memory/LFSR reference.
// Instance A uses fixed latency 2, instance B uses pseudo-random stalls.
module tb_imem_stall_responder;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b, wr;
  logic [31:0] addr, din;
  logic [31:0] dout_a, dout_b;
  logic        rdy_a, rdy_b, err_a, err_b;
  logic        busy_a, busy_b;

  always #5 clk = ~clk;

  imem_stall_responder #(
    .DEPTH_WORDS(DEPTH), .LATENCY(2), .RAND_STALL(1'b0)
  ) u_a (
    .clk(clk), .rst(rst), .enable(en_a), .wr(wr),
    .addr(addr), .data_in(din), .data_out(dout_a),
    .ready(rdy_a), .err(err_a), .busy(busy_a)
  );

  imem_stall_responder #(
    .DEPTH_WORDS(DEPTH), .LATENCY(2), .RAND_STALL(1'b1),
    .LFSR_SEED(8'hA5)
  ) u_b (
    .clk(clk), .rst(rst), .enable(en_b), .wr(wr),
    .addr(addr), .data_in(din), .data_out(dout_b),
    .ready(rdy_b), .err(err_b), .busy(busy_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem_a [int];
  logic [31:0] mem_b [int];
  logic [31:0] last_a, last_b;
  logic [7:0]  lfsr_m;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    int unsigned u;
    u = a;
    return (u % 4 != 0) || (u / 4 >= DEPTH);
  endfunction

  // Next stall of instance B from the seed sequence; steps the model.
  function automatic int next_lat();
    int l;
    logic fb;
    l = 1 + int'(lfsr_m & 8'h03);
    fb = lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3];
    lfsr_m = {lfsr_m[6:0], fb};
    return l;
  endfunction

  // Issue one request, called #1 after an edge with the DUT idle.
  task automatic req(input bit sel, input bit w,
                     input logic [31:0] a, input logic [31:0] d,
                     input int exp_lat, input bit scramble);
    int n;
    bit r;
    bit bad;
    logic [31:0] exp_d;
    int idx;
    wr = w; addr = a; din = d;
    if (sel) en_b = 1'b1; else en_a = 1'b1;
    @(posedge clk); #1;
    en_a = 1'b0; en_b = 1'b0;
    if (scramble) begin
      addr = $urandom; din = $urandom; wr = 1'($urandom);
    end
    n = 0;
    r = sel ? rdy_b : rdy_a;
    while (!r && n < 40) begin
      chk("busy", 32'(sel ? busy_b : busy_a), 32'd1);
      @(posedge clk); #1;
      n++;
      r = sel ? rdy_b : rdy_a;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    bad = is_bad(a);
    idx = int'(a[31:2]);
    chk("err", 32'(sel ? err_b : err_a), 32'(bad));
    exp_d = sel ? last_b : last_a;
    if (bad) exp_d = NOP;
    else if (!w) exp_d = sel ? mem_b[idx] : mem_a[idx];
    chk("data_out", sel ? dout_b : dout_a, exp_d);
    if (sel) last_b = exp_d; else last_a = exp_d;
    if (w && !bad) begin
      if (sel) mem_b[idx] = d; else mem_a[idx] = d;
    end
    @(posedge clk); #1;
    chk("ready_drop", 32'(sel ? rdy_b : rdy_a), 32'd0);
    chk("idle_busy", 32'(sel ? busy_b : busy_a), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int k;
    rst = 1'b1; en_a = 1'b1; en_b = 1'b0;
    wr = 1'b1; addr = 32'h10; din = 32'hDEADBEEF;
    last_a = NOP; last_b = NOP; lfsr_m = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout_a", dout_a, NOP);
    chk("rst_rdy_a", 32'(rdy_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_err_a", 32'(err_a), 32'd0);
    chk("rst_dout_b", dout_b, NOP);
    rst = 1'b0;
    // held enable accepted at first edge after reset release
    req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2, 1'b0);
    req(1'b0, 1'b0, 32'h10, 32'h0, 2, 1'b0);
    req(1'b0, 1'b1, 32'h20, 32'h12345678, 2, 1'b0);
    req(1'b0, 1'b0, 32'h20, 32'h0, 2, 1'b0);
    req(1'b0, 1'b0, 32'h0000000E, 32'h0, 2, 1'b0);
    req(1'b0, 1'b0, 32'(4 * DEPTH), 32'h0, 2, 1'b0);
    req(1'b0, 1'b1, 32'h21, 32'hCAFEF00D, 2, 1'b0);
    req(1'b0, 1'b1, 32'(4 * DEPTH + 32), 32'hCAFEF00D, 2, 1'b0);
    req(1'b0, 1'b0, 32'h20, 32'h0, 2, 1'b0);

    // reset during BUSY drops the pending write
    wr = 1'b1; addr = 32'h20; din = 32'hBAD0BAD0; en_a = 1'b1;
    @(posedge clk); #1;
    en_a = 1'b0;
    chk("abort_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_a = NOP; last_b = NOP; lfsr_m = 8'hA5;
    chk("abort_dout", dout_a, NOP);
    chk("abort_busy0", 32'(busy_a), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_rdy", 32'(rdy_a), 32'd0);
      @(posedge clk); #1;
    end
    req(1'b0, 1'b0, 32'h20, 32'h0, 2, 1'b0);

    // random traffic on fixed-latency instance
    for (int i = 0; i < 16; i++)
      req(1'b0, 1'b1, 32'(i * 4), $urandom, 2, 1'b0);
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(7);
      a = 32'($urandom_range(15) * 4);
      if (k == 0) a = a + 32'($urandom_range(3, 1));
      if (k == 1) a = a + 32'(4 * DEPTH);
      req(1'b0, 1'($urandom), a, $urandom, 2, 1'b1);
    end

    // pseudo-random stalls: writes then back-to-back reads
    for (int i = 0; i < 8; i++)
      req(1'b1, 1'b1, 32'(i * 4), $urandom, next_lat(), 1'b1);
    for (int i = 0; i < 8; i++) begin
      a = 32'($urandom_range(7) * 4);
      req(1'b1, 1'b0, a, 32'h0, next_lat(), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
